zap_fetch_buffer: RTL and testbench
===================================

Name: zap_fetch_buffer

Overview:
Instruction queue between the I-cache/fetch stage and the 16-bit (Thumb) decode stage.
- Absorbs fetched words while the downstream pipeline stalls.
- Presents one registered entry per advance: instruction, PC, PC+8, predictor state, abort flag.
- Flushes completely on any pipeline clear.
- Decouples code-side stalls from decode-side stalls.

Parameters:
DEPTH, 4, number of entries; must be a power of 2, minimum 2.
PTR_W, 2, log2(DEPTH); pointer width.

Ports:
i_clk  input  1  core clock
i_reset  input  1  synchronous reset, active high
i_clear  input  1  flush (OR of writeback, ALU and decode clears)
i_wr_en  input  1  fetch word valid from I-cache
i_instruction  input  32  fetched word
i_pc_ff  input  32  address of fetched word
i_taken  input  2  branch predictor state for word
i_iabort  input  1  instruction abort for word
o_full  output  1  queue full; fetch must stall
o_empty  output  1  queue empty
o_count  output  PTR_W+1  occupied entries
i_rd_en  input  1  downstream advance (no stall downstream)
o_instruction  output  32  head instruction
o_instruction_valid  output  1  output register holds valid entry
o_pc_ff  output  32  PC of output entry
o_pc_plus_8_ff  output  32  PC+8 of output entry
o_taken_ff  output  2  predictor state of output entry
o_iabort  output  1  abort flag of output entry

Behaviour:
- Clock and reset: reset is i_reset (synchronous, active-high); clock is i_clk.
- Storage: DEPTH x 67-bit entries {iabort, taken[1:0], pc[31:0], instruction[31:0]}. Write pointer, read pointer and count are registers.
- Pointer arithmetic: pointers wrap modulo DEPTH (natural PTR_W-bit overflow).
- Status outputs: count is PTR_W+1 bits. o_full = (count == DEPTH). o_empty = (count == 0). Both derive from registered count.
- Write: on i_wr_en=1 and o_full=0, store the entry at wptr and increment wptr. A write while o_full=1 is dropped, even if a pop occurs in the same cycle; fetch is responsible for holding the word.
- Output stage, i_rd_en=1, queue not empty: pop head into the output register and set o_instruction_valid=1. Increment rptr.
- Output stage, i_rd_en=1, queue empty: o_instruction_valid=0 and o_iabort=0. Data fields hold.
- Output stage, i_rd_en=0: all outputs hold.
- o_pc_plus_8_ff = popped pc + 8, a 32-bit wrapping add computed at pop time.
- Count update:
  - +1 on an accepted write with no pop.
  - -1 on a pop with no accepted write.
  - Unchanged when both or neither occur.
  - Simultaneous write and pop at count 0 is impossible, because a pop requires count > 0. The written word is not bypassed and appears on the next pop.
- Latency: a word written at edge N is popped at the earliest on edge N+1, so o_instruction_valid rises after edge N+1.
- Clear (i_clear=1): wptr=rptr=0, count=0, o_instruction_valid=0, o_iabort=0. Clear overrides i_wr_en and i_rd_en in the same cycle; the incoming word is discarded. Data fields are not required to change.
- Reset: same as clear, and additionally o_instruction=0, o_pc_ff=0, o_pc_plus_8_ff=0, o_taken_ff=0. Reset has priority over clear. Reset mid-operation discards all contents.
- Abort entries pass through unchanged. An abort entry occupies one slot like any other; the instruction field is don't-care.
- Ordering: strict FIFO. No reordering and no duplication.

Test Plan:
1. Reset, then 3 idle cycles -> o_empty=1, o_full=0, o_count=0, o_instruction_valid=0, all data outputs 0.
2. i_rd_en=0; write 0xE1A00000@0x100, 0xE3A01001@0x104, 0xE0811002@0x108, 0xEAFFFFFE@0x10C; then write 0xDEADBEEF -> o_full=1 after 4th write, 5th write dropped. Four pops yield the four words in order; o_pc_plus_8_ff = 0x108, 0x10C, 0x110, 0x114.
3. Count 2; same-cycle write 0x11111111 and i_rd_en=1 -> o_count stays 2, popped entry is the oldest, 0x11111111 emerges 2 pops later.
4. Count 3, o_instruction_valid=1; assert i_clear with i_wr_en=1 and i_rd_en=1 -> next cycle o_count=0, o_instruction_valid=0, o_iabort=0. The written word is never popped.
5. Write an entry with i_iabort=1, i_taken=2'b10 at pc 0xFFFFFFFC -> popped o_iabort=1, o_taken_ff=2'b10, o_pc_plus_8_ff=0x00000004 (wrap).
6. Push/pop 10 words alternating across pointer wrap -> order preserved. o_count never exceeds 1. Popping when empty gives o_instruction_valid=0 with data held.

Source files
------------

// File: rtl/zap_fetch_buffer.sv
// ----------------------------------------------------------------------------
// zap_fetch_buffer
//   Instruction queue between the I-cache/fetch stage and the Thumb decode
//   stage. It holds fetched words while decode stalls, so that code-side
//   stalls and decode-side stalls are decoupled. On each downstream advance
//   it presents one registered entry: instruction, PC, PC+8, predictor state
//   and abort flag. Any pipeline clear flushes the queue completely.
//
// Ports
//   i_clk, i_reset        core clock, synchronous active-high reset
//   i_clear               pipeline flush (OR of writeback/ALU/decode clears)
//   i_wr_en               fetch word valid from I-cache
//   i_instruction         fetched word
//   i_pc_ff               address of fetched word
//   i_taken               branch predictor state for the word
//   i_iabort              instruction abort for the word
//   o_full                queue full, so fetch must stall
//   o_empty               queue empty
//   o_count               number of occupied entries
//   i_rd_en               downstream advance (no stall downstream)
//   o_instruction         head instruction (registered)
//   o_instruction_valid   output register holds a valid entry
//   o_pc_ff               PC of the output entry
//   o_pc_plus_8_ff        PC+8 of the output entry
//   o_taken_ff            predictor state of the output entry
//   o_iabort              abort flag of the output entry
// ----------------------------------------------------------------------------
module zap_fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [31:0]      i_instruction,
    input  logic [31:0]      i_pc_ff,
    input  logic [1:0]       i_taken,
    input  logic             i_iabort,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    input  logic             i_rd_en,
    output logic [31:0]      o_instruction,
    output logic             o_instruction_valid,
    output logic [31:0]      o_pc_ff,
    output logic [31:0]      o_pc_plus_8_ff,
    output logic [1:0]       o_taken_ff,
    output logic             o_iabort
);

    localparam int unsigned CNT_W = PTR_W + 1;

    // One 67-bit queue entry.
    typedef struct packed {
        logic        iabort;
        logic [1:0]  taken;
        logic [31:0] pc;
        logic [31:0] instruction;
    } entry_t;

    // Reject parameter sets the pointer arithmetic cannot support.
    generate
        if (DEPTH < 2 || (32'd1 << PTR_W) != DEPTH) begin : g_bad_param
            $error("zap_fetch_buffer: DEPTH must be a power of 2 >= 2 and equal 2**PTR_W");
        end
    endgenerate

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic   wr_accept;
    logic   pop;
    entry_t wr_entry;
    entry_t head;

    // Status flags come straight from the registered count.
    assign o_count = count;
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == CNT_W'(0));

    // A write into a full queue is dropped even when a pop happens alongside.
    assign wr_accept = i_wr_en & ~o_full;
    assign pop       = i_rd_en & ~o_empty;

    assign wr_entry = '{iabort:      i_iabort,
                        taken:       i_taken,
                        pc:          i_pc_ff,
                        instruction: i_instruction};

    assign head = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear && wr_accept) begin
            mem[wptr] <= wr_entry;
        end
    end

    // Output register: loaded on advance, valid drops when advancing empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
            o_instruction       <= '0;
            o_pc_ff             <= '0;
            o_pc_plus_8_ff      <= '0;
            o_taken_ff          <= '0;
        end else if (i_clear) begin
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
        end else if (i_rd_en) begin
            if (pop) begin
                o_instruction_valid <= 1'b1;
                o_iabort            <= head.iabort;
                o_instruction       <= head.instruction;
                o_pc_ff             <= head.pc;
                o_pc_plus_8_ff      <= head.pc + 32'd8;
                o_taken_ff          <= head.taken;
            end else begin
                o_instruction_valid <= 1'b0;
                o_iabort            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zap_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_zap_fetch_buffer
//   Bench for zap_fetch_buffer: a queue-based reference model checked against
//   the DUT on every clock, hand-computed literal expectations for the
//   directed scenarios, and a randomized traffic phase.
// ----------------------------------------------------------------------------
module tb_zap_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_clear;
    logic             i_wr_en;
    logic [31:0]      i_instruction;
    logic [31:0]      i_pc_ff;
    logic [1:0]       i_taken;
    logic             i_iabort;
    logic             o_full;
    logic             o_empty;
    logic [PTR_W:0]   o_count;
    logic             i_rd_en;
    logic [31:0]      o_instruction;
    logic             o_instruction_valid;
    logic [31:0]      o_pc_ff;
    logic [31:0]      o_pc_plus_8_ff;
    logic [1:0]       o_taken_ff;
    logic             o_iabort;

    zap_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_clear             (i_clear),
        .i_wr_en             (i_wr_en),
        .i_instruction       (i_instruction),
        .i_pc_ff             (i_pc_ff),
        .i_taken             (i_taken),
        .i_iabort            (i_iabort),
        .o_full              (o_full),
        .o_empty             (o_empty),
        .o_count             (o_count),
        .i_rd_en             (i_rd_en),
        .o_instruction       (o_instruction),
        .o_instruction_valid (o_instruction_valid),
        .o_pc_ff             (o_pc_ff),
        .o_pc_plus_8_ff      (o_pc_plus_8_ff),
        .o_taken_ff          (o_taken_ff),
        .o_iabort            (o_iabort)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  taken;
        logic        abort;
    } item_t;

    item_t       q[$];
    logic        m_valid;
    logic        m_abort;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc8;
    logic [1:0]  m_taken;
    bit          m_known  = 1'b0;
    bit          checking = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Literal expectations posted by the stimulus for the coming edge.
    string       pin_name = "";
    bit          pin_count_en = 0, pin_valid_en = 0, pin_instr_en = 0;
    bit          pin_pc8_en = 0, pin_abort_en = 0, pin_taken_en = 0;
    bit          pin_full_en = 0, pin_empty_en = 0, pin_pc_en = 0;
    logic [31:0] pin_count, pin_instr, pin_pc8, pin_pc;
    logic        pin_valid, pin_abort, pin_full, pin_empty;
    logic [1:0]  pin_taken;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the sampled inputs.
    task automatic model_step();
        item_t e;
        bit    was_full;
        if (i_reset) begin
            q.delete();
            m_valid = 1'b0; m_abort = 1'b0;
            m_instr = '0; m_pc = '0; m_pc8 = '0; m_taken = '0;
            m_known = 1'b1;
            checking = 1'b1;
        end else if (i_clear) begin
            q.delete();
            m_valid = 1'b0; m_abort = 1'b0;
            m_known = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (i_rd_en) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_valid = 1'b1; m_abort = e.abort;
                    m_instr = e.instr; m_pc = e.pc; m_pc8 = e.pc + 32'd8;
                    m_taken = e.taken; m_known = 1'b1;
                end else begin
                    m_valid = 1'b0; m_abort = 1'b0;
                end
            end
            if (i_wr_en && !was_full) begin
                e.instr = i_instruction; e.pc = i_pc_ff;
                e.taken = i_taken; e.abort = i_iabort;
                q.push_back(e);
            end
        end
    endtask

    // Single compare process: model every cycle, plus posted literals.
    always @(posedge i_clk) begin
        model_step();
        #1;
        if (checking) begin
            cmp("count", 32'(o_count), 32'(q.size()));
            cmp("full", 32'(o_full), 32'(q.size() == DEPTH));
            cmp("empty", 32'(o_empty), 32'(q.size() == 0));
            cmp("valid", 32'(o_instruction_valid), 32'(m_valid));
            cmp("iabort", 32'(o_iabort), 32'(m_abort));
            if (m_known) begin
                cmp("instr", o_instruction, m_instr);
                cmp("pc", o_pc_ff, m_pc);
                cmp("pc8", o_pc_plus_8_ff, m_pc8);
                cmp("taken", 32'(o_taken_ff), 32'(m_taken));
            end
        end
        if (pin_count_en) begin
            cmp({pin_name, " count"}, 32'(o_count), pin_count);
            cmp({pin_name, " model count"}, 32'(q.size()), pin_count);
        end
        if (pin_valid_en) begin
            cmp({pin_name, " valid"}, 32'(o_instruction_valid), 32'(pin_valid));
            cmp({pin_name, " model valid"}, 32'(m_valid), 32'(pin_valid));
        end
        if (pin_instr_en) begin
            cmp({pin_name, " instr"}, o_instruction, pin_instr);
            cmp({pin_name, " model instr"}, m_instr, pin_instr);
        end
        if (pin_pc_en) begin
            cmp({pin_name, " pc"}, o_pc_ff, pin_pc);
        end
        if (pin_pc8_en) begin
            cmp({pin_name, " pc8"}, o_pc_plus_8_ff, pin_pc8);
            cmp({pin_name, " model pc8"}, m_pc8, pin_pc8);
        end
        if (pin_abort_en) begin
            cmp({pin_name, " iabort"}, 32'(o_iabort), 32'(pin_abort));
        end
        if (pin_taken_en) begin
            cmp({pin_name, " taken"}, 32'(o_taken_ff), 32'(pin_taken));
        end
        if (pin_full_en) begin
            cmp({pin_name, " full"}, 32'(o_full), 32'(pin_full));
        end
        if (pin_empty_en) begin
            cmp({pin_name, " empty"}, 32'(o_empty), 32'(pin_empty));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_pins();
        pin_count_en = 0; pin_valid_en = 0; pin_instr_en = 0; pin_pc_en = 0;
        pin_pc8_en = 0; pin_abort_en = 0; pin_taken_en = 0;
        pin_full_en = 0; pin_empty_en = 0;
    endtask

    // Apply inputs for one edge, then return at the following negedge.
    task automatic drive(input logic wr, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] taken, input logic abort, input logic rd,
                         input logic clr, input logic rst);
        i_wr_en = wr; i_instruction = instr; i_pc_ff = pc; i_taken = taken;
        i_iabort = abort; i_rd_en = rd; i_clear = clr; i_reset = rst;
        @(negedge i_clk);
        clear_pins();
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        drive(1'b1, instr, pc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_count(input int n);
        pin_count_en = 1; pin_count = 32'(n);
    endtask

    task automatic exp_out(input logic v, input logic [31:0] instr, input logic [31:0] pc8);
        pin_valid_en = 1; pin_valid = v;
        pin_instr_en = 1; pin_instr = instr;
        pin_pc8_en = 1;   pin_pc8 = pc8;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'hE1A00000; words[1] = 32'hE3A01001;
        words[2] = 32'hE0811002; words[3] = 32'hEAFFFFFE;
        clear_pins();

        // Reset, then idle cycles: everything empty and zeroed.
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        pin_name = "reset";
        exp_count(0); exp_out(1'b0, 32'h0, 32'h0);
        pin_pc_en = 1; pin_pc = 32'h0;
        pin_full_en = 1; pin_full = 1'b0; pin_empty_en = 1; pin_empty = 1'b1;
        pin_abort_en = 1; pin_abort = 1'b0; pin_taken_en = 1; pin_taken = 2'b00;
        idle();

        // Fill to full, then a dropped write, then drain in order.
        pin_name = "fill";
        for (int i = 0; i < 4; i++) begin
            exp_count(i + 1);
            if (i == 3) begin pin_full_en = 1; pin_full = 1'b1; end
            push(words[i], 32'h100 + 32'(4 * i));
        end
        pin_name = "drop"; exp_count(4); pin_full_en = 1; pin_full = 1'b1;
        push(32'hDEADBEEF, 32'h110);
        pin_name = "drain";
        for (int i = 0; i < 4; i++) begin
            exp_count(3 - i);
            exp_out(1'b1, words[i], 32'h108 + 32'(4 * i));
            pop();
        end

        // Simultaneous write and pop keeps count; new word emerges later.
        push(32'h22222222, 32'h200);
        push(32'h33333333, 32'h204);
        pin_name = "wr+rd";
        exp_count(2); exp_out(1'b1, 32'h22222222, 32'h208);
        drive(1'b1, 32'h11111111, 32'h208, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_count(1); exp_out(1'b1, 32'h33333333, 32'h20C);
        pop();
        exp_count(0); exp_out(1'b1, 32'h11111111, 32'h210);
        pop();

        // Clear with write and advance in the same cycle.
        for (int i = 0; i < 4; i++) push(32'h40000000 + 32'(i), 32'h400 + 32'(4 * i));
        pin_name = "pre-clear"; exp_count(3);
        pin_valid_en = 1; pin_valid = 1'b1;
        pop();
        pin_name = "clear"; exp_count(0);
        pin_valid_en = 1; pin_valid = 1'b0; pin_abort_en = 1; pin_abort = 1'b0;
        pin_empty_en = 1; pin_empty = 1'b1;
        drive(1'b1, 32'h55555555, 32'h500, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        pin_name = "post-clear"; exp_count(0);
        pin_valid_en = 1; pin_valid = 1'b0;
        pop();

        // Abort entry at the top of the address space wraps PC+8.
        drive(1'b1, 32'h0, 32'hFFFFFFFC, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        pin_name = "abort";
        pin_abort_en = 1; pin_abort = 1'b1; pin_taken_en = 1; pin_taken = 2'b10;
        pin_pc_en = 1; pin_pc = 32'hFFFFFFFC;
        pin_pc8_en = 1; pin_pc8 = 32'h00000004;
        pin_valid_en = 1; pin_valid = 1'b1;
        pop();

        // Alternating push/pop across several pointer wraps.
        pin_name = "alt";
        for (int i = 0; i < 10; i++) begin
            exp_count(1);
            push(32'h60000000 + 32'(i), 32'h600 + 32'(4 * i));
            exp_count(0);
            exp_out(1'b1, 32'h60000000 + 32'(i), 32'h608 + 32'(4 * i));
            pop();
        end
        pin_name = "empty-pop";
        exp_out(1'b0, 32'h60000009, 32'h608 + 32'd36);
        pin_abort_en = 1; pin_abort = 1'b0;
        pop();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 6),
                  $urandom(), $urandom(),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 255) == 0));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
